// File: rtl/apb_bridge_arbiter_pkg.sv
// Shared types for the APB bridge arbiter: FSM encoding, lock limit and an index-width helper.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LOCK_MAX = 16;

    // Ceiling log2, never below 1 so a vector of this width always exists.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/apb_bridge_arbiter_if.sv
// Requester and bridge signal bundle for apb_bridge_arbiter; m_lock exists only when APB_ARB_LOCK_EN is defined.
interface apb_bridge_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    // Requesters hold m_req until their one-cycle m_done; br_valid is a single-cycle strobe and
    // the bridge answers with a single-cycle br_done (m_err/m_rdata are valid only with m_done).
    logic [NUM_MASTERS-1:0]        m_req;
    logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
    logic [NUM_MASTERS-1:0]        m_write;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
    logic [NUM_MASTERS-1:0]        m_gnt;
    logic [NUM_MASTERS-1:0]        m_done;
    logic                          m_err;
    logic [DATA_W-1:0]             m_rdata;
    logic                          br_valid;
    logic [ADDR_W-1:0]             br_haddr;
    logic                          br_hwrite;
    logic [DATA_W-1:0]             br_hwdata;
    logic                          br_done;
    logic [DATA_W-1:0]             br_rdata;
`ifdef APB_ARB_LOCK_EN
    logic [NUM_MASTERS-1:0]        m_lock;

    modport master (
        input  m_req, m_addr, m_write, m_wdata, m_lock, br_done, br_rdata,
        output m_gnt, m_done, m_err, m_rdata, br_valid, br_haddr, br_hwrite, br_hwdata
    );
    modport slave (
        output m_req, m_addr, m_write, m_wdata, m_lock, br_done, br_rdata,
        input  m_gnt, m_done, m_err, m_rdata, br_valid, br_haddr, br_hwrite, br_hwdata
    );
`else
    modport master (
        input  m_req, m_addr, m_write, m_wdata, br_done, br_rdata,
        output m_gnt, m_done, m_err, m_rdata, br_valid, br_haddr, br_hwrite, br_hwdata
    );
    modport slave (
        output m_req, m_addr, m_write, m_wdata, br_done, br_rdata,
        input  m_gnt, m_done, m_err, m_rdata, br_valid, br_haddr, br_hwrite, br_hwdata
    );
`endif

endinterface

// File: rtl/apb_bridge_arbiter_rr_pick.sv
// Combinational round-robin picker: first request strictly after the pointer, wrapping around.
module rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    logic [IDX_W-1:0] w_sel;

    // Walk from the farthest candidate to the nearest so the nearest match is the last write.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sel = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_sel = IDX_W'((int'(i_ptr) + k) % NUM_MASTERS);
            if (i_req[w_sel]) begin
                o_gnt        = '0;
                o_gnt[w_sel] = 1'b1;
                o_idx        = w_sel;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter feeding one AHB-to-APB bridge from NUM_MASTERS requesters, all outputs registered.
// Optional APB_ARB_LOCK_EN adds m_lock: a locked winner keeps the bridge for up to LOCK_MAX grants.
module apb_bridge_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 hclk,
    input  logic                 hreset,
    apb_bridge_arbiter_if.master bus,
    output state_t               o_dbg_state
);

    localparam int IDX_W = clog2(NUM_MASTERS);
    localparam int CNT_W = clog2(TIMEOUT_CYCLES);

    state_t                 r_state, w_nxt_state;
    logic [NUM_MASTERS-1:0] r_gnt, w_nxt_gnt;
    logic [NUM_MASTERS-1:0] r_done, w_nxt_done;
    logic                   r_err, w_nxt_err;
    logic [DATA_W-1:0]      r_rdata, w_nxt_rdata;
    logic                   r_valid, w_nxt_valid;
    logic [ADDR_W-1:0]      r_haddr, w_nxt_haddr;
    logic                   r_hwrite, w_nxt_hwrite;
    logic [DATA_W-1:0]      r_hwdata, w_nxt_hwdata;
    logic [CNT_W-1:0]       r_cnt, w_nxt_cnt;
    logic [IDX_W-1:0]       r_ptr, w_nxt_ptr;
    logic [IDX_W-1:0]       r_win, w_nxt_win;
    logic [NUM_MASTERS-1:0] w_pick_oh;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
`ifdef APB_ARB_LOCK_EN
    localparam int LOCK_W = clog2(LOCK_MAX);
    logic [LOCK_W-1:0]      r_lock_cnt, w_nxt_lock_cnt;
`endif

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .i_req (bus.m_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_ff @(posedge hclk) begin
        if (hreset) r_state <= ST_IDLE;
        else        r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_gnt    = r_gnt;
        w_nxt_done   = '0;
        w_nxt_err    = 1'b0;
        w_nxt_rdata  = r_rdata;
        w_nxt_valid  = 1'b0;
        w_nxt_haddr  = r_haddr;
        w_nxt_hwrite = r_hwrite;
        w_nxt_hwdata = r_hwdata;
        w_nxt_cnt    = r_cnt;
        w_nxt_ptr    = r_ptr;
        w_nxt_win    = r_win;
`ifdef APB_ARB_LOCK_EN
        w_nxt_lock_cnt = r_lock_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_nxt_state = ST_ISSUE;
                    w_nxt_gnt   = w_pick_oh;
                    w_nxt_valid = 1'b1;
                    w_nxt_win   = w_pick_idx;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        if (w_pick_oh[i]) begin
                            w_nxt_haddr  = bus.m_addr[i*ADDR_W +: ADDR_W];
                            w_nxt_hwrite = bus.m_write[i];
                            w_nxt_hwdata = bus.m_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_ISSUE: begin
                w_nxt_state = ST_WAIT;
                w_nxt_cnt   = '0;
            end
            ST_WAIT: begin
                // A completion arriving on the last allowed cycle beats the timeout.
                if (bus.br_done) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_gnt   = '0;
                    w_nxt_done  = r_gnt;
                    w_nxt_rdata = bus.br_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_gnt   = '0;
                    w_nxt_done  = r_gnt;
                    w_nxt_err   = 1'b1;
                    w_nxt_rdata = '0;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_nxt_state = ST_IDLE;
`ifdef APB_ARB_LOCK_EN
                // Parking the pointer just before the winner makes it the next pick unconditionally.
                if (bus.m_lock[r_win] && bus.m_req[r_win] &&
                    (r_lock_cnt < LOCK_W'(LOCK_MAX - 1))) begin
                    w_nxt_ptr      = (r_win == '0) ? IDX_W'(NUM_MASTERS - 1) : r_win - 1'b1;
                    w_nxt_lock_cnt = r_lock_cnt + 1'b1;
                end else begin
                    w_nxt_ptr      = r_win;
                    w_nxt_lock_cnt = '0;
                end
`else
                w_nxt_ptr = r_win;
`endif
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_valid  <= 1'b0;
            r_haddr  <= '0;
            r_hwrite <= 1'b0;
            r_hwdata <= '0;
            r_cnt    <= '0;
            r_ptr    <= IDX_W'(NUM_MASTERS - 1);
            r_win    <= '0;
        end else begin
            r_gnt    <= w_nxt_gnt;
            r_done   <= w_nxt_done;
            r_err    <= w_nxt_err;
            r_rdata  <= w_nxt_rdata;
            r_valid  <= w_nxt_valid;
            r_haddr  <= w_nxt_haddr;
            r_hwrite <= w_nxt_hwrite;
            r_hwdata <= w_nxt_hwdata;
            r_cnt    <= w_nxt_cnt;
            r_ptr    <= w_nxt_ptr;
            r_win    <= w_nxt_win;
        end
    end

`ifdef APB_ARB_LOCK_EN
    always_ff @(posedge hclk) begin
        if (hreset) r_lock_cnt <= '0;
        else        r_lock_cnt <= w_nxt_lock_cnt;
    end
`endif

    assign bus.m_gnt     = r_gnt;
    assign bus.m_done    = r_done;
    assign bus.m_err     = r_err;
    assign bus.m_rdata   = r_rdata;
    assign bus.br_valid  = r_valid;
    assign bus.br_haddr  = r_haddr;
    assign bus.br_hwrite = r_hwrite;
    assign bus.br_hwdata = r_hwdata;
    assign o_dbg_state   = r_state;

endmodule
